// File: rtl/mem_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the MEM stage: memory operation codes (same numbering
// as decode/EX), data_mem address translation constants, FSM state encoding
// and a helper returning the access size of an operation.
// ---------------------------------------------------------------------------
package mem_access_stage_pkg;

   typedef enum logic [2:0] {
      MEM_OP_LB  = 3'd0,
      MEM_OP_LBU = 3'd1,
      MEM_OP_LH  = 3'd2,
      MEM_OP_LHU = 3'd3,
      MEM_OP_LW  = 3'd4,
      MEM_OP_SB  = 3'd5,
      MEM_OP_SH  = 3'd6,
      MEM_OP_SW  = 3'd7
   } mem_op_e;

   // Physical address of data_mem byte 0 and highest valid byte offset.
   localparam logic [31:0] DM_BASE_ADDR = 32'h8002_0000;
   localparam int unsigned DM_DEPTH     = 1000000;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SH2  = 1'b1
   } state_e;

   // Number of bytes touched by an operation: 1, 2 or 4.
   function automatic logic [2:0] op_size(input mem_op_e op);
      case (op)
         MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB:  op_size = 3'd1;
         MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:  op_size = 3'd2;
         default:                           op_size = 3'd4;
      endcase
   endfunction

   // Stores are the three highest codes.
   function automatic logic op_is_store(input mem_op_e op);
      op_is_store = (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
   endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// ---------------------------------------------------------------------------
// mem_access_stage_load_extend (load_extend)
// Combinational extraction and extension of load data. data_mem returns the
// big-endian word starting at the access address, so the addressed byte or
// halfword is always in the most significant bits.
// Ports:
//   i_op        in   3   memory operation code
//   i_rdata_32  in   32  word read from data_mem (bytes addr..addr+3)
//   o_data_32   out  32  sign/zero-extended load value
// ---------------------------------------------------------------------------
module mem_access_stage_load_extend
   import mem_access_stage_pkg::*;
(
   input  logic [2:0]  i_op,
   input  logic [31:0] i_rdata_32,
   output logic [31:0] o_data_32
);

   mem_op_e w_op;
   assign w_op = mem_op_e'(i_op);

   always_comb begin
      o_data_32 = i_rdata_32;
      case (w_op)
         MEM_OP_LB:  o_data_32 = {{24{i_rdata_32[31]}}, i_rdata_32[31:24]};
         MEM_OP_LBU: o_data_32 = {24'h000000, i_rdata_32[31:24]};
         MEM_OP_LH:  o_data_32 = {{16{i_rdata_32[31]}}, i_rdata_32[31:16]};
         MEM_OP_LHU: o_data_32 = {16'h0000, i_rdata_32[31:16]};
         default:    o_data_32 = i_rdata_32;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the MIPS pipeline, sitting directly in front of data_mem.
// Accepts one load/store per cycle from EX/MEM, checks range and alignment,
// drives data_mem, extends load data and returns a registered response.
// SH is split into two byte writes (data_mem writes only bytes or words),
// which makes SH occupy the stage for two cycles.
//
// Handshake: a request is accepted on a rising edge where w_req_valid and
// w_req_ready are both high; w_req_ready is low only during the second SH
// cycle. The response is a single-cycle w_resp_valid pulse that is never
// back-pressured; the other w_resp_* outputs hold between pulses.
//
// Ports:
//   clock, w_reset_n          clock / async active-low reset
//   w_req_valid/ready         request handshake
//   w_req_op/addr/wdata/rd    request fields
//   w_resp_valid/is_load/rd/data_32/addr_err   registered response
//   w_dm_addr/data/en/write_op/byte_op         data_mem controls
//   w_dm_rdata_32             combinational read data from data_mem
//   w_dbg_state               current FSM state (0 idle, 1 second SH byte)
// ---------------------------------------------------------------------------
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR,
   parameter int unsigned MEM_DEPTH   = DM_DEPTH,
   parameter bit          CHECK_ALIGN = 1'b1
)(
   input  logic        clock,
   input  logic        w_reset_n,
   input  logic        w_req_valid,
   output logic        w_req_ready,
   input  logic [2:0]  w_req_op,
   input  logic [31:0] w_req_addr_32,
   input  logic [31:0] w_req_wdata_32,
   input  logic [4:0]  w_req_rd,
   output logic        w_resp_valid,
   output logic        w_resp_is_load,
   output logic [4:0]  w_resp_rd,
   output logic [31:0] w_resp_data_32,
   output logic        w_resp_addr_err,
   output logic [31:0] w_dm_addr_32,
   output logic [31:0] w_dm_data_32,
   output logic        w_dm_en,
   output logic        w_dm_write_op,
   output logic        w_dm_byte_op,
   input  logic [31:0] w_dm_rdata_32,
   output logic        w_dbg_state
);

   localparam logic [32:0] DEPTH_33 = 33'(MEM_DEPTH);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [31:0] r_sh_addr;
   logic [7:0]  r_sh_byte;

   logic        r_resp_valid;
   logic        r_resp_is_load;
   logic [4:0]  r_resp_rd;
   logic [31:0] r_resp_data;
   logic        r_resp_err;

   mem_op_e     w_op;
   logic        w_store;
   logic        w_load;
   logic        w_accept;
   logic [2:0]  w_size;
   logic [31:0] w_off;
   logic [32:0] w_last;
   logic        w_below;
   logic        w_over;
   logic        w_misalign;
   logic        w_err;
   logic [31:0] w_ext;

   assign w_op    = mem_op_e'(w_req_op);
   assign w_store = op_is_store(w_op);
   assign w_load  = ~w_store;
   assign w_size  = op_size(w_op);

   // Range check in 33 bits so off + size - 1 cannot wrap past zero.
   assign w_off   = w_req_addr_32 - BASE_ADDR;
   assign w_last  = {1'b0, w_off} + {30'd0, w_size} - 33'd1;
   assign w_below = (w_req_addr_32 < BASE_ADDR);
   assign w_over  = (w_last > DEPTH_33);

   always_comb begin
      w_misalign = 1'b0;
      if (CHECK_ALIGN) begin
         case (w_op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: w_misalign = w_req_addr_32[0];
            MEM_OP_LW, MEM_OP_SW:             w_misalign = |w_req_addr_32[1:0];
            default:                          w_misalign = 1'b0;
         endcase
      end
   end

   assign w_err    = w_below | w_over | w_misalign;
   assign w_accept = w_req_valid & w_req_ready;

   mem_access_stage_load_extend u_load_extend (
      .i_op       (w_req_op),
      .i_rdata_32 (w_dm_rdata_32),
      .o_data_32  (w_ext)
   );

   // FSM state register
   always_ff @(posedge clock or negedge w_reset_n) begin
      if (!w_reset_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   // Next state and data_mem port muxing
   always_comb begin
      w_state_nxt   = r_state;
      w_req_ready   = 1'b0;
      w_dm_addr_32  = w_req_addr_32;
      w_dm_data_32  = 32'h0;
      w_dm_en       = 1'b0;
      w_dm_write_op = 1'b0;
      w_dm_byte_op  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_ready   = 1'b1;
            w_dm_addr_32  = w_req_addr_32;
            w_dm_en       = w_req_valid & ~w_err;
            w_dm_write_op = w_req_valid & w_store & ~w_err;
            w_dm_byte_op  = (w_op == MEM_OP_SB) || (w_op == MEM_OP_SH);
            case (w_op)
               MEM_OP_SB: w_dm_data_32 = {24'h000000, w_req_wdata_32[7:0]};
               // High byte goes first, at the lower (big-endian) address.
               MEM_OP_SH: w_dm_data_32 = {24'h000000, w_req_wdata_32[15:8]};
               MEM_OP_SW: w_dm_data_32 = w_req_wdata_32;
               default:   w_dm_data_32 = 32'h0;
            endcase
            if (w_req_valid && (w_op == MEM_OP_SH) && !w_err) w_state_nxt = S_SH2;
         end
         S_SH2: begin
            w_dm_addr_32  = r_sh_addr;
            w_dm_data_32  = {24'h000000, r_sh_byte};
            w_dm_en       = 1'b1;
            w_dm_write_op = 1'b1;
            w_dm_byte_op  = 1'b1;
            w_state_nxt   = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Second SH byte held for the S_SH2 cycle
   always_ff @(posedge clock or negedge w_reset_n) begin
      if (!w_reset_n) begin
         r_sh_addr <= 32'h0;
         r_sh_byte <= 8'h00;
      end else if (w_accept && (w_op == MEM_OP_SH)) begin
         r_sh_addr <= w_req_addr_32 + 32'd1;
         r_sh_byte <= w_req_wdata_32[7:0];
      end
   end

   // Registered response; fields other than valid hold between pulses.
   always_ff @(posedge clock or negedge w_reset_n) begin
      if (!w_reset_n) begin
         r_resp_valid   <= 1'b0;
         r_resp_is_load <= 1'b0;
         r_resp_rd      <= 5'd0;
         r_resp_data    <= 32'h0;
         r_resp_err     <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         if (r_state == S_SH2) begin
            r_resp_valid   <= 1'b1;
            r_resp_is_load <= 1'b0;
            r_resp_data    <= 32'h0;
            r_resp_err     <= 1'b0;
         end else if (w_accept && !((w_op == MEM_OP_SH) && !w_err)) begin
            // A valid SH responds after its second byte instead.
            r_resp_valid   <= 1'b1;
            r_resp_is_load <= w_load;
            r_resp_rd      <= w_req_rd;
            r_resp_data    <= (w_load && !w_err) ? w_ext : 32'h0;
            r_resp_err     <= w_err;
         end
      end
   end

   assign w_resp_valid    = r_resp_valid;
   assign w_resp_is_load  = r_resp_is_load;
   assign w_resp_rd       = r_resp_rd;
   assign w_resp_data_32  = r_resp_data;
   assign w_resp_addr_err = r_resp_err;
   assign w_dbg_state     = r_state;

endmodule
